// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: issue and writeback stage wrapped around an 8-bit signed ALU.
//
// Accepts 16-bit instructions over a valid/ready handshake, reads operands from
// a small signed register file, drives the ALU for one cycle, captures its
// magnitude+sign result and writes the two's-complement value back.
//
// Instruction format:
//   [15:13] opcode, [12:10] dst, [9:7] src1, [6:4] src2, [7:0] imm (LOADI only)
// Opcodes: 000 NOP, 001 ADD, 010 MUL, 111 LOADI, others illegal (dropped).
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   instr_valid/ready    instruction handshake
//   instr                instruction word
//   alu_enable/code      ALU control (registered, valid during EXEC only)
//   alu_in1/alu_in2      ALU operands (registered, valid during EXEC only)
//   alu_result/alu_sign  ALU magnitude and sign, captured at the end of EXEC
//   done                 one-cycle pulse when an instruction retires
//   illegal_op           one-cycle pulse when an unsupported opcode is dropped
//   dbg_addr/dbg_data    combinational register-file read port
//
// Optional build macro ALU_SEQ_STATUS_EN adds:
//   flag_zero            last written value was zero
//   flag_neg             bit 7 of the last written value
//   flag_sticky_wrap     an ADD returned magnitude 0 with sign 1; cleared by reset only

module alu_op_sequencer #(
   parameter int unsigned NREGS = 8,
   parameter int unsigned DW    = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          instr_valid,
   output logic          instr_ready,
   input  logic [15:0]   instr,
   output logic          alu_enable,
   output logic [2:0]    alu_code,
   output logic [DW-1:0] alu_in1,
   output logic [DW-1:0] alu_in2,
   input  logic [DW-1:0] alu_result,
   input  logic          alu_sign,
   output logic          done,
   output logic          illegal_op,
   input  logic [2:0]    dbg_addr,
`ifdef ALU_SEQ_STATUS_EN
   output logic          flag_zero,
   output logic          flag_neg,
   output logic          flag_sticky_wrap,
`endif
   output logic [DW-1:0] dbg_data
);

   localparam int unsigned AW = $clog2(NREGS);

   localparam logic [2:0] OpNop   = 3'b000;
   localparam logic [2:0] OpAdd   = 3'b001;
   localparam logic [2:0] OpMul   = 3'b010;
   localparam logic [2:0] OpLoadi = 3'b111;

   typedef enum logic [1:0] {StIdle, StExec, StWb} state_e;

   state_e          state_q, state_d;
   logic [DW-1:0]   regs_q [NREGS];

   logic            is_add_q, is_add_d;
   logic [AW-1:0]   dst_q, dst_d;
   logic [DW-1:0]   res_mag_q, res_mag_d;
   logic            res_sign_q, res_sign_d;

   logic            alu_enable_d;
   logic [2:0]      alu_code_d;
   logic [DW-1:0]   alu_in1_d, alu_in2_d;
   logic            done_d, illegal_op_d;

   logic            we;
   logic [AW-1:0]   waddr;
   logic [DW-1:0]   wdata;
   logic [DW-1:0]   wb_value;

   logic [2:0]      opcode;
   logic [AW-1:0]   instr_dst, instr_src1, instr_src2;

   assign opcode     = instr[15:13];
   assign instr_dst  = instr[10 +: AW];
   assign instr_src1 = instr[7 +: AW];
   assign instr_src2 = instr[4 +: AW];

   assign instr_ready = (state_q == StIdle);
   assign dbg_data    = regs_q[dbg_addr[AW-1:0]];

   // ADD returns sign+magnitude; negate back to two's complement. Magnitude 0
   // with sign 1 (the -256 wrap) naturally negates to 0x00 modulo 2^DW.
   // MUL already delivers the Q1.7 slice, so its sign is not applied.
   assign wb_value = (is_add_q && res_sign_q) ? DW'(~res_mag_q + DW'(1)) : res_mag_q;

   always_comb begin
      state_d      = state_q;
      is_add_d     = is_add_q;
      dst_d        = dst_q;
      res_mag_d    = res_mag_q;
      res_sign_d   = res_sign_q;
      alu_enable_d = 1'b0;
      alu_code_d   = 3'b000;
      alu_in1_d    = '0;
      alu_in2_d    = '0;
      done_d       = 1'b0;
      illegal_op_d = 1'b0;
      we           = 1'b0;
      waddr        = dst_q;
      wdata        = wb_value;

      unique case (state_q)
         StIdle: begin
            if (instr_valid) begin
               case (opcode)
                  OpAdd, OpMul: begin
                     is_add_d     = (opcode == OpAdd);
                     dst_d        = instr_dst;
                     alu_enable_d = 1'b1;
                     alu_code_d   = opcode;
                     alu_in1_d    = regs_q[instr_src1];
                     alu_in2_d    = regs_q[instr_src2];
                     state_d      = StExec;
                  end
                  OpLoadi: begin
                     we     = 1'b1;
                     waddr  = instr_dst;
                     wdata  = instr[7:0];
                     done_d = 1'b1;
                  end
                  OpNop: begin
                     done_d = 1'b1;
                  end
                  default: begin
                     illegal_op_d = 1'b1;
                  end
               endcase
            end
         end
         StExec: begin
            res_mag_d  = alu_result;
            res_sign_d = alu_sign;
            // Registered, so done is high throughout the WB cycle.
            done_d     = 1'b1;
            state_d    = StWb;
         end
         StWb: begin
            we      = 1'b1;
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         is_add_q   <= 1'b0;
         dst_q      <= '0;
         res_mag_q  <= '0;
         res_sign_q <= 1'b0;
         alu_enable <= 1'b0;
         alu_code   <= 3'b000;
         alu_in1    <= '0;
         alu_in2    <= '0;
         done       <= 1'b0;
         illegal_op <= 1'b0;
      end else begin
         state_q    <= state_d;
         is_add_q   <= is_add_d;
         dst_q      <= dst_d;
         res_mag_q  <= res_mag_d;
         res_sign_q <= res_sign_d;
         alu_enable <= alu_enable_d;
         alu_code   <= alu_code_d;
         alu_in1    <= alu_in1_d;
         alu_in2    <= alu_in2_d;
         done       <= done_d;
         illegal_op <= illegal_op_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) begin
            regs_q[i] <= '0;
         end
      end else if (we) begin
         regs_q[waddr] <= wdata;
      end
   end

`ifdef ALU_SEQ_STATUS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flag_zero        <= 1'b0;
         flag_neg         <= 1'b0;
         flag_sticky_wrap <= 1'b0;
      end else if (we) begin
         flag_zero <= (wdata == '0);
         flag_neg  <= wdata[DW-1];
         if (state_q == StWb && is_add_q && res_sign_q && res_mag_q == '0) begin
            flag_sticky_wrap <= 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed self-checking bench for alu_op_sequencer with a small behavioural
// ALU model (sign+magnitude ADD, Q1.7 MUL) attached to the ALU ports.

module tb_alu_op_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        instr_valid;
   logic        instr_ready;
   logic [15:0] instr;
   logic        alu_enable;
   logic [2:0]  alu_code;
   logic [7:0]  alu_in1, alu_in2;
   logic [7:0]  alu_result;
   logic        alu_sign;
   logic        done, illegal_op;
   logic [2:0]  dbg_addr;
   logic [7:0]  dbg_data;
`ifdef ALU_SEQ_STATUS_EN
   logic        flag_zero, flag_neg, flag_sticky_wrap;
`endif

   int n_tests = 0;
   int n_fail  = 0;
   logic [7:0] exp_regs [8];
   logic [7:0] rd;

   always #5 clk = ~clk;

   alu_op_sequencer dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .instr       (instr),
      .alu_enable  (alu_enable),
      .alu_code    (alu_code),
      .alu_in1     (alu_in1),
      .alu_in2     (alu_in2),
      .alu_result  (alu_result),
      .alu_sign    (alu_sign),
      .done        (done),
      .illegal_op  (illegal_op),
      .dbg_addr    (dbg_addr),
`ifdef ALU_SEQ_STATUS_EN
      .flag_zero        (flag_zero),
      .flag_neg         (flag_neg),
      .flag_sticky_wrap (flag_sticky_wrap),
`endif
      .dbg_data    (dbg_data)
   );

   // ALU model
   logic [8:0]  sum, sum_abs;
   logic [15:0] prod;
   always_comb begin
      sum        = {alu_in1[7], alu_in1} + {alu_in2[7], alu_in2};
      sum_abs    = sum[8] ? (~sum + 9'd1) : sum;
      prod       = {{8{alu_in1[7]}}, alu_in1} * {{8{alu_in2[7]}}, alu_in2};
      alu_result = 8'h00;
      alu_sign   = 1'b0;
      if (alu_enable) begin
         if (alu_code == 3'b001) begin
            alu_result = sum_abs[7:0];
            alu_sign   = sum[8];
         end else if (alu_code == 3'b010) begin
            alu_result = prod[14:7];
            alu_sign   = prod[15];
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] mk(input logic [2:0] op, input logic [2:0] d,
                                      input logic [2:0] s1, input logic [2:0] s2);
      return {op, d, s1, s2, 4'h0};
   endfunction

   function automatic logic [15:0] mk_loadi(input logic [2:0] d, input logic [7:0] imm);
      return {3'b111, d, 2'b00, imm};
   endfunction

   // Present one instruction for one accept edge; returns at edge + 1.
   task automatic issue(input logic [15:0] ins);
      @(negedge clk);
      instr_valid = 1'b1;
      instr       = ins;
      @(posedge clk);
      #1;
      instr_valid = 1'b0;
      instr       = 16'h0;
   endtask

   task automatic read_reg(input logic [2:0] a, output logic [7:0] d);
      dbg_addr = a;
      #1;
      d = dbg_data;
   endtask

   task automatic sweep(input string tag);
      for (int i = 0; i < 8; i++) begin
         read_reg(3'(i), rd);
         check($sformatf("%s_r%0d", tag, i), {24'h0, rd}, {24'h0, exp_regs[i]});
      end
   endtask

   // Issue an ADD/MUL and check EXEC, WB and the final write.
   task automatic run_alu(input string tag, input logic [15:0] ins, input logic [7:0] in1,
                          input logic [7:0] in2, input logic [7:0] result);
      logic [2:0] d;
      d = ins[12:10];
      issue(ins);
      check({tag, "_exec_en"}, {31'h0, alu_enable}, 32'h1);
      check({tag, "_exec_code"}, {29'h0, alu_code}, {29'h0, ins[15:13]});
      check({tag, "_exec_in1"}, {24'h0, alu_in1}, {24'h0, in1});
      check({tag, "_exec_in2"}, {24'h0, alu_in2}, {24'h0, in2});
      check({tag, "_exec_rdy"}, {31'h0, instr_ready}, 32'h0);
      check({tag, "_exec_done"}, {31'h0, done}, 32'h0);
      @(posedge clk);
      #1;
      check({tag, "_wb_done"}, {31'h0, done}, 32'h1);
      check({tag, "_wb_en"}, {31'h0, alu_enable}, 32'h0);
      check({tag, "_wb_rdy"}, {31'h0, instr_ready}, 32'h0);
      read_reg(d, rd);
      check({tag, "_wb_old"}, {24'h0, rd}, {24'h0, exp_regs[d]});
      @(posedge clk);
      #1;
      exp_regs[d] = result;
      check({tag, "_idle_done"}, {31'h0, done}, 32'h0);
      check({tag, "_idle_rdy"}, {31'h0, instr_ready}, 32'h1);
      read_reg(d, rd);
      check({tag, "_result"}, {24'h0, rd}, {24'h0, result});
   endtask

   initial begin
      rst_n       = 1'b0;
      instr_valid = 1'b0;
      instr       = 16'h0;
      dbg_addr    = 3'd0;
      for (int i = 0; i < 8; i++) exp_regs[i] = 8'h00;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;

      // Reset state
      check("rst_ready", {31'h0, instr_ready}, 32'h1);
      check("rst_en", {31'h0, alu_enable}, 32'h0);
      check("rst_code", {29'h0, alu_code}, 32'h0);
      check("rst_in1", {24'h0, alu_in1}, 32'h0);
      check("rst_in2", {24'h0, alu_in2}, 32'h0);
      check("rst_done", {31'h0, done}, 32'h0);
      check("rst_ill", {31'h0, illegal_op}, 32'h0);
      sweep("rst");

      // Back-to-back LOADIs
      issue(mk_loadi(3'd1, 8'h05));
      check("ld1_done", {31'h0, done}, 32'h1);
      issue(mk_loadi(3'd2, 8'hFD));
      check("ld2_done", {31'h0, done}, 32'h1);
      exp_regs[1] = 8'h05;
      exp_regs[2] = 8'hFD;
      read_reg(3'd1, rd);
      check("ld_r1", {24'h0, rd}, 32'h05);
      read_reg(3'd2, rd);
      check("ld_r2", {24'h0, rd}, 32'hFD);
      @(posedge clk);
      #1;
      check("ld_done_clr", {31'h0, done}, 32'h0);

      // ADD r3 = r1 + r2 -> 2; a held LOADI during EXEC/WB must be ignored
      fork
         run_alu("add_r3", mk(3'b001, 3'd3, 3'd1, 3'd2), 8'h05, 8'hFD, 8'h02);
         begin
            @(negedge clk);
            @(negedge clk);
            instr_valid = 1'b1;
            instr       = mk_loadi(3'd5, 8'h77);
            @(negedge clk);
            instr_valid = 1'b0;
            instr       = 16'h0;
         end
      join
      read_reg(3'd5, rd);
      check("ignored_r5", {24'h0, rd}, 32'h00);

      // ADD r4 = r2 + r2 -> -6
      run_alu("add_r4", mk(3'b001, 3'd4, 3'd2, 3'd2), 8'hFD, 8'hFD, 8'hFA);
`ifdef ALU_SEQ_STATUS_EN
      check("add_r4_neg", {31'h0, flag_neg}, 32'h1);
      check("add_r4_zero", {31'h0, flag_zero}, 32'h0);
      check("add_r4_sticky", {31'h0, flag_sticky_wrap}, 32'h0);
`endif

      // dst == src uses the old value: r1 = 5 + 5
      run_alu("add_r1", mk(3'b001, 3'd1, 3'd1, 3'd1), 8'h05, 8'h05, 8'h0A);

      // MUL r6 = 0.5 * 0.5 in Q1.7
      issue(mk_loadi(3'd5, 8'h40));
      exp_regs[5] = 8'h40;
      run_alu("mul_r6", mk(3'b010, 3'd6, 3'd5, 3'd5), 8'h40, 8'h40, 8'h20);

      // LOADI r0 immediately followed by ADD reading r0: -128 + -128 wraps
      issue(mk_loadi(3'd0, 8'h80));
      exp_regs[0] = 8'h80;
      run_alu("add_wrap", mk(3'b001, 3'd7, 3'd0, 3'd0), 8'h80, 8'h80, 8'h00);
`ifdef ALU_SEQ_STATUS_EN
      check("wrap_sticky", {31'h0, flag_sticky_wrap}, 32'h1);
      check("wrap_zero", {31'h0, flag_zero}, 32'h1);
      check("wrap_neg", {31'h0, flag_neg}, 32'h0);
`endif

      // NOP
      issue(mk(3'b000, 3'd2, 3'd0, 3'd0));
      check("nop_done", {31'h0, done}, 32'h1);
      check("nop_ill", {31'h0, illegal_op}, 32'h0);

      // Illegal opcode 101
      issue(mk(3'b101, 3'd2, 3'd1, 3'd1));
      check("ill_pulse", {31'h0, illegal_op}, 32'h1);
      check("ill_done", {31'h0, done}, 32'h0);
      check("ill_en", {31'h0, alu_enable}, 32'h0);
      @(posedge clk);
      #1;
      check("ill_clr", {31'h0, illegal_op}, 32'h0);
      sweep("ill");

      // Reset during EXEC of an ADD
      issue(mk(3'b001, 3'd2, 3'd1, 3'd1));
      check("mid_exec_en", {31'h0, alu_enable}, 32'h1);
      rst_n = 1'b0;
      #1;
      check("mrst_ready", {31'h0, instr_ready}, 32'h1);
      check("mrst_en", {31'h0, alu_enable}, 32'h0);
      check("mrst_code", {29'h0, alu_code}, 32'h0);
      check("mrst_in1", {24'h0, alu_in1}, 32'h0);
      check("mrst_done", {31'h0, done}, 32'h0);
`ifdef ALU_SEQ_STATUS_EN
      check("mrst_sticky", {31'h0, flag_sticky_wrap}, 32'h0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) exp_regs[i] = 8'h00;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk);
         #1;
         check($sformatf("post_rst_done%0d", c), {31'h0, done}, 32'h0);
      end
      sweep("post_rst");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
